mem_stage: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline, placed between EX and WB. It holds the data memory and the MEM/WB pipeline register. Each cycle it takes one instruction bundle from EX, performs the store or load against data memory, and registers the bundle plus load data toward WB. It honours stall and flush from the hazard unit.

---
 rtl/mem_stage.sv | 200 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MIPS MEM stage: data memory plus MEM/WB pipeline register.
// Optional half/byte access support is enabled with the MEM_SUBWORD_EN macro.
module mem_stage #(
    parameter int unsigned DM_WORDS = 1024,
    parameter logic [31:0] DM_BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] instructure_in,
    input  logic [5:0]  instr_code_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] mem_write_data_in,
    input  logic        mem_write_en_in,
    input  logic        mem_read_en_in,
    input  logic [1:0]  mem_size_in,
    input  logic        mem_sign_in,
    input  logic        stall_in,
    input  logic        flush_in,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] instructure_out,
    output logic [5:0]  instr_code_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] mem_read_data_out,
    output logic        misalign_out
);

    localparam int unsigned AW = $clog2(DM_WORDS);

    logic [31:0]   mem_q [DM_WORDS];

    logic [31:0]   addr_off_s;
    logic [AW-1:0] word_idx_s;
    logic [31:0]   rd_word_s;
    logic          act_s;
    logic          access_s;
    logic          misaligned_addr_s;
    logic [31:0]   load_data_s;
    logic [31:0]   mem_word_d;
    logic          mem_we_d;

    logic          valid_d,    valid_q;
    logic [31:0]   pc_d,       pc_q;
    logic [31:0]   instr_d,    instr_q;
    logic [5:0]    code_d,     code_q;
    logic [31:0]   alu_d,      alu_q;
    logic [31:0]   rdata_d,    rdata_q;
    logic          misalign_d, misalign_q;

    // Only the word-index bits of the offset address the array; the rest wrap away.
    logic unused_addr_s;
    assign unused_addr_s = ^addr_off_s;

`ifdef MEM_SUBWORD_EN
    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

    logic [31:0] byte_mask_s;
    logic [31:0] wr_data_s;
    logic [7:0]  byte_lane_s;

    // Lane selection, alignment check and store merge for word/half/byte accesses.
    always_comb begin
        misaligned_addr_s = 1'b0;
        byte_mask_s       = 32'hFFFF_FFFF;
        wr_data_s         = mem_write_data_in;
        byte_lane_s       = rd_word_s[7:0];
        load_data_s       = rd_word_s;
        case (mem_size_in)
            2'b01: begin
                misaligned_addr_s = alu_result_in[0];
                wr_data_s         = {2{mem_write_data_in[15:0]}};
                if (alu_result_in[1]) begin
                    byte_mask_s = 32'hFFFF_0000;
                    load_data_s = ext16(rd_word_s[31:16], mem_sign_in);
                end else begin
                    byte_mask_s = 32'h0000_FFFF;
                    load_data_s = ext16(rd_word_s[15:0], mem_sign_in);
                end
            end
            2'b10: begin
                wr_data_s = {4{mem_write_data_in[7:0]}};
                case (alu_result_in[1:0])
                    2'b00: begin byte_mask_s = 32'h0000_00FF; byte_lane_s = rd_word_s[7:0];   end
                    2'b01: begin byte_mask_s = 32'h0000_FF00; byte_lane_s = rd_word_s[15:8];  end
                    2'b10: begin byte_mask_s = 32'h00FF_0000; byte_lane_s = rd_word_s[23:16]; end
                    default: begin byte_mask_s = 32'hFF00_0000; byte_lane_s = rd_word_s[31:24]; end
                endcase
                load_data_s = ext8(byte_lane_s, mem_sign_in);
            end
            default: begin
                misaligned_addr_s = (alu_result_in[1:0] != 2'b00);
            end
        endcase
        mem_word_d = (rd_word_s & ~byte_mask_s) | (wr_data_s & byte_mask_s);
    end
`else
    logic unused_cfg_s;
    assign unused_cfg_s = ^{mem_size_in, mem_sign_in};

    // Word-only build: every access is a full word.
    always_comb begin
        misaligned_addr_s = (alu_result_in[1:0] != 2'b00);
        load_data_s       = rd_word_s;
        mem_word_d        = mem_write_data_in;
    end
`endif

    // Address decode, combinational array read and write enable.
    always_comb begin
        addr_off_s = alu_result_in - DM_BASE;
        word_idx_s = addr_off_s[AW+1:2];
        rd_word_s  = mem_q[word_idx_s];
        act_s      = valid_in & ~stall_in & ~flush_in;
        access_s   = valid_in & (mem_write_en_in | mem_read_en_in);
        mem_we_d   = act_s & mem_write_en_in & ~misaligned_addr_s;
    end

    // Next MEM/WB bundle: flush beats stall, stall holds, otherwise capture EX.
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        code_d     = code_q;
        alu_d      = alu_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        if (flush_in) begin
            valid_d    = 1'b0;
            pc_d       = 32'h0;
            instr_d    = 32'h0;
            code_d     = 6'h0;
            alu_d      = 32'h0;
            rdata_d    = 32'h0;
            misalign_d = 1'b0;
        end else if (stall_in) begin
            valid_d    = valid_q;
        end else begin
            valid_d    = valid_in;
            pc_d       = pc_in;
            instr_d    = instructure_in;
            code_d     = instr_code_in;
            alu_d      = alu_result_in;
            misalign_d = access_s & misaligned_addr_s;
            if (valid_in & mem_read_en_in & ~misaligned_addr_s) begin
                rdata_d = load_data_s;
            end else begin
                rdata_d = 32'h0;
            end
        end
    end

    // Data memory array; cleared on reset so reads after reset are deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DM_WORDS; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (mem_we_d) begin
            mem_q[word_idx_s] <= mem_word_d;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= 32'h0;
            instr_q    <= 32'h0;
            code_q     <= 6'h0;
            alu_q      <= 32'h0;
            rdata_q    <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            code_q     <= code_d;
            alu_q      <= alu_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end

    assign valid_out         = valid_q;
    assign pc_out            = pc_q;
    assign instructure_out   = instr_q;
    assign instr_code_out    = code_q;
    assign alu_result_out    = alu_q;
    assign mem_read_data_out = rdata_q;
    assign misalign_out      = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (sub-word steps only when MEM_SUBWORD_EN is defined).
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] pc_in;
    logic [31:0] instructure_in;
    logic [5:0]  instr_code_in;
    logic [31:0] alu_result_in;
    logic [31:0] mem_write_data_in;
    logic        mem_write_en_in;
    logic        mem_read_en_in;
    logic [1:0]  mem_size_in;
    logic        mem_sign_in;
    logic        stall_in;
    logic        flush_in;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] instructure_out;
    logic [5:0]  instr_code_out;
    logic [31:0] alu_result_out;
    logic [31:0] mem_read_data_out;
    logic        misalign_out;

    int checks = 0;
    int errors = 0;

    mem_stage #(.DM_WORDS(1024), .DM_BASE(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .pc_in(pc_in),
        .instructure_in(instructure_in), .instr_code_in(instr_code_in),
        .alu_result_in(alu_result_in), .mem_write_data_in(mem_write_data_in),
        .mem_write_en_in(mem_write_en_in), .mem_read_en_in(mem_read_en_in),
        .mem_size_in(mem_size_in), .mem_sign_in(mem_sign_in),
        .stall_in(stall_in), .flush_in(flush_in), .valid_out(valid_out),
        .pc_out(pc_out), .instructure_out(instructure_out),
        .instr_code_out(instr_code_out), .alu_result_out(alu_result_out),
        .mem_read_data_out(mem_read_data_out), .misalign_out(misalign_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic v, input logic we, input logic re,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] size, input logic sgn,
                          input logic st, input logic fl,
                          input logic [31:0] pc, input logic [5:0] code);
        valid_in          = v;
        mem_write_en_in   = we;
        mem_read_en_in    = re;
        alu_result_in     = addr;
        mem_write_data_in = wd;
        mem_size_in       = size;
        mem_sign_in       = sgn;
        stall_in          = st;
        flush_in          = fl;
        pc_in             = pc;
        instructure_in    = ~pc;
        instr_code_in     = code;
    endtask

    task automatic op(input logic v, input logic we, input logic re,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [1:0] size, input logic sgn,
                      input logic st, input logic fl,
                      input logic [31:0] pc, input logic [5:0] code);
        set_op(v, we, re, addr, wd, size, sgn, st, fl, pc, code);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 6'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_rdata", mem_read_data_out, 32'h0);
        chk("rst_misalign", {31'd0, misalign_out}, 32'd0);
        rst_n = 1'b1;

        // load 0x0 after reset
        op(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h100, 6'h23);
        chk("load0_rdata", mem_read_data_out, 32'h0);
        chk("load0_valid", {31'd0, valid_out}, 32'd1);
        chk("load0_pc", pc_out, 32'h100);
        chk("load0_instr", instructure_out, ~32'h100);
        chk("load0_code", {26'd0, instr_code_out}, 32'h23);

        // word store then load in the next cycle
        op(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0, 1'b0, 32'h104, 6'h2B);
        chk("st10_rdata", mem_read_data_out, 32'h0);
        chk("st10_alu", alu_result_out, 32'h10);
        op(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h108, 6'h23);
        chk("ld10_rdata", mem_read_data_out, 32'hDEAD_BEEF);
        chk("ld10_misalign", {31'd0, misalign_out}, 32'd0);

`ifdef MEM_SUBWORD_EN
        op(1'b1, 1'b1, 1'b0, 32'h13, 32'h0000_0080, 2'b10, 1'b0, 1'b0, 1'b0, 32'h10C, 6'h28);
        chk("sb13_misalign", {31'd0, misalign_out}, 32'd0);
        op(1'b1, 1'b0, 1'b1, 32'h13, 32'h0, 2'b10, 1'b1, 1'b0, 1'b0, 32'h110, 6'h20);
        chk("lb13_rdata", mem_read_data_out, 32'hFFFF_FF80);
        op(1'b1, 1'b0, 1'b1, 32'h12, 32'h0, 2'b01, 1'b0, 1'b0, 1'b0, 32'h114, 6'h25);
        chk("lhu12_rdata", mem_read_data_out, 32'h0000_80AD);
        op(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h118, 6'h24);
        chk("lbu10_rdata", mem_read_data_out, 32'h0000_00EF);
        op(1'b1, 1'b0, 1'b1, 32'h11, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h11C, 6'h21);
        chk("lh11_misalign", {31'd0, misalign_out}, 32'd1);
        chk("lh11_rdata", mem_read_data_out, 32'h0);
        op(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0, 1'b0, 32'h120, 6'h2B);
`endif

        // misaligned word store writes nothing
        op(1'b1, 1'b1, 1'b0, 32'h21, 32'h1234_5678, 2'b00, 1'b0, 1'b0, 1'b0, 32'h130, 6'h2B);
        chk("st21_misalign", {31'd0, misalign_out}, 32'd1);
        op(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h134, 6'h23);
        chk("ld20_rdata", mem_read_data_out, 32'h0);
        chk("ld20_misalign", {31'd0, misalign_out}, 32'd0);
        op(1'b1, 1'b0, 1'b1, 32'h12, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h138, 6'h23);
        chk("ld12w_misalign", {31'd0, misalign_out}, 32'd1);
        chk("ld12w_rdata", mem_read_data_out, 32'h0);

        // stall holds outputs and blocks the store
        op(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h200, 6'h23);
        op(1'b1, 1'b1, 1'b0, 32'h10, 32'h1111_1111, 2'b00, 1'b0, 1'b1, 1'b0, 32'h204, 6'h2B);
        chk("stall_pc", pc_out, 32'h200);
        chk("stall_rdata", mem_read_data_out, 32'hDEAD_BEEF);
        chk("stall_code", {26'd0, instr_code_out}, 32'h23);
        op(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h208, 6'h23);
        chk("stall_mem", mem_read_data_out, 32'hDEAD_BEEF);

        // flush together with stall: bubble, no write
        op(1'b1, 1'b1, 1'b0, 32'h10, 32'h2222_2222, 2'b00, 1'b0, 1'b1, 1'b1, 32'h20C, 6'h2B);
        chk("flush_valid", {31'd0, valid_out}, 32'd0);
        chk("flush_code", {26'd0, instr_code_out}, 32'h0);
        chk("flush_pc", pc_out, 32'h0);
        chk("flush_rdata", mem_read_data_out, 32'h0);
        op(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h210, 6'h23);
        chk("flush_mem", mem_read_data_out, 32'hDEAD_BEEF);

        // invalid bundle never writes
        op(1'b0, 1'b1, 1'b0, 32'h10, 32'h3333_3333, 2'b00, 1'b0, 1'b0, 1'b0, 32'h214, 6'h2B);
        chk("inv_valid", {31'd0, valid_out}, 32'd0);
        op(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h218, 6'h23);
        chk("inv_mem", mem_read_data_out, 32'hDEAD_BEEF);

        // address wrap: 0x1000 aliases word 0
        op(1'b1, 1'b1, 1'b0, 32'h1000, 32'hA5A5_A5A5, 2'b00, 1'b0, 1'b0, 1'b0, 32'h300, 6'h2B);
        op(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h304, 6'h23);
        chk("wrap_rdata", mem_read_data_out, 32'hA5A5_A5A5);
        chk("wrap_alu", alu_result_out, 32'h0);

        // reset mid-cycle: outputs clear at once, pending store lost, array cleared
        set_op(1'b1, 1'b1, 1'b0, 32'h30, 32'h7777_7777, 2'b00, 1'b0, 1'b0, 1'b0, 32'h400, 6'h2B);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, valid_out}, 32'd0);
        chk("arst_pc", pc_out, 32'h0);
        chk("arst_rdata", mem_read_data_out, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        op(1'b1, 1'b0, 1'b1, 32'h30, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h404, 6'h23);
        chk("arst_lost", mem_read_data_out, 32'h0);
        op(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h408, 6'h23);
        chk("arst_clear", mem_read_data_out, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
